cache_reader: RTL and testbench
===============================

// Module: cache_reader
// PURPOSE
// Read side of the pixel cache that fill_cache writes. Accepts pixel coordinates relative to the cache window and checks them against the valid region.
// Hit: reads the cache RAM and extracts the byte. Miss: returns BORDER_PIXEL. Sits between the cache RAM and the interpolation datapath.
// PARAMETERS
// DATA_SIZE     32    cache RAM word width; 4 pixels of 8 bits per word
// ADDR_SIZE_W   5     cache width up to 2**ADDR_SIZE_W pixels
// ADDR_SIZE_H   5     cache height up to 2**ADDR_SIZE_H lines
// BORDER_PIXEL  8'h00 value returned on a miss
// PORTS
// p_clk       in   1                        system clock
// p_resetn    in   1                        async reset, active low
// cache_rdy   in   1                        cache filled and valid (from fill_cache)
// decalage_w  in   10                       column offset of the valid region in the window
// decalage_h  in   10                       line offset of the valid region in the window
// cache_w     in   10                       valid region width, pixels
// cache_h     in   10                       valid region height, lines
// req_valid   in   1                        coordinate request valid
// req_ready   out  1                        request accepted when valid&&ready
// req_x       in   ADDR_SIZE_W              column in the window
// req_y       in   ADDR_SIZE_H              line in the window
// pix_valid   out  1                        output pixel valid
// pix_ready   in   1                        downstream accepts the pixel
// pix_data    out  8                        pixel value
// pix_hit     out  1                        1 = read from cache, 0 = border
// miss_cnt    out  16                       saturating miss count since last IDLE->SERVE
// ram_addr    out  ADDR_SIZE_W+ADDR_SIZE_H  cache RAM word address
// ram_re      out  1                        cache RAM read enable
// ram_rdata   in   DATA_SIZE                RAM data, valid 1 cycle after ram_re
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; FIFO and pipeline empty; miss_cnt 0. Reset mid-operation drops in-flight requests.
// - FSM IDLE: req_ready=0. Goes to SERVE when cache_rdy=1.
//   On that edge: latch decalage_*/cache_*; clear miss_cnt.
// - FSM SERVE: accepts requests. Goes to DRAIN when cache_rdy=0.
// - FSM DRAIN: req_ready=0. Goes to IDLE when s1_valid=0 and fifo_occ=0.
// - Window values are used only as latched, so in-flight requests are unaffected by input changes.
// - req_ready = (state==SERVE) && cache_rdy && (fifo_occ + s1_valid < 3). Registered terms only; no path from pix_ready.
// - Hit test: dw <= x < dw+cw AND dh <= y < dh+ch. Compare at 11 bits, no wrap.
// - Hit addressing: rx = x-dw, ry = y-dh; ram_addr = zero-extend({ry, rx[ADDR_SIZE_W-1:2]}).
// - ram_re = 1 in the accept cycle for hits only. Misses leave ram_addr/ram_re at 0.
// - Stage 1 (next cycle) holds s1_valid, hit, rx[1:0].
//   pix = hit ? ram_rdata[8*rx[1:0] +: 8] : BORDER_PIXEL (byte 0 = bits 7:0).
//   Result is pushed into a 3-entry FIFO.
// - Latency: accept at edge N gives pix_valid at cycle N+2 if the FIFO was empty. Sustains 1 pixel per cycle when pix_ready=1.
// - Output: FIFO head drives pix_valid/pix_data/pix_hit. Pop on pix_valid&&pix_ready; push and pop in the same cycle keeps occupancy.
// - pix_* stay stable while pix_valid && !pix_ready.
// - Order: pixels leave in request order, including hit/miss mixes.
// - miss_cnt: +1 per accepted miss; saturates at 16'hFFFF.
// - cache_rdy falling with the FIFO full: no new accepts; all queued pixels still delivered.
// STRUCTURE
// - cache_pkg: PIX_W=8, PIX_PER_WORD=DATA_SIZE/PIX_W, enum rd_state_t {IDLE,SERVE,DRAIN}, default BORDER_PIXEL.
// - One sub-module, pix_fifo: 3-entry sync FIFO, width 9 (pixel+hit), occupancy output. Everything else in cache_reader.
// TESTING
// 1. dw=dh=0, cw=ch=32; RAM word 5 = 32'hDDCCBBAA; req (x=22,y=0), i.e. word 5 byte 2.
//    -> ram_addr=5, pix_data=8'hCC, pix_hit=1 at accept+2.
// 2. dw=4, cw=10, BORDER_PIXEL=8'h00; requests x=3,4,13,14 on y=0.
//    -> hit pattern 0,1,1,0; ram_re only for x=4,13; miss_cnt=2.
// 3. 64 back-to-back hits with pix_ready=1.
//    -> req_ready never drops; 64 pixels in order; one per cycle after a 2-cycle fill.
// 4. pix_ready=0 while streaming.
//    -> req_ready drops after at most 3 accepts; pix_data stable; on release, all pixels delivered, none lost or duplicated.
// 5. cache_rdy drops with 2 pixels queued.
//    -> DRAIN, req_ready=0, both delivered, then IDLE. cache_rdy re-rise -> SERVE with miss_cnt=0.
// 6. p_resetn asserted mid-stream.
//    -> pix_valid, req_ready, ram_re = 0 immediately; state IDLE.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the pixel cache read side.
// Pure declarations, no timing.
// No flow control of its own.
package cache_pkg;

  localparam int PIX_W         = 8;
  localparam int DATA_SIZE_DEF = 32;
  localparam int PIX_PER_WORD  = DATA_SIZE_DEF / PIX_W;
  localparam int FIFO_DEPTH    = 3;

  localparam logic [PIX_W-1:0] BORDER_PIXEL_DEF = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  // Pointer increment for the 3-entry output FIFO (wraps 2 -> 0).
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/cache_reader_if.sv
// Bundle of request, pixel, window and RAM signals around cache_reader.
// Wires only, no latency.
// req_valid/req_ready and pix_valid/pix_ready are independent handshakes.
interface cache_reader_if #(
  parameter int DATA_SIZE   = 32,
  parameter int ADDR_SIZE_W = 5,
  parameter int ADDR_SIZE_H = 5
);
  import cache_pkg::*;

  logic                             cache_rdy;
  logic [9:0]                       decalage_w;
  logic [9:0]                       decalage_h;
  logic [9:0]                       cache_w;
  logic [9:0]                       cache_h;
  logic                             req_valid;
  logic                             req_ready;
  logic [ADDR_SIZE_W-1:0]           req_x;
  logic [ADDR_SIZE_H-1:0]           req_y;
  logic                             pix_valid;
  logic                             pix_ready;
  logic [PIX_W-1:0]                 pix_data;
  logic                             pix_hit;
  logic [15:0]                      miss_cnt;
  logic [ADDR_SIZE_W+ADDR_SIZE_H-1:0] ram_addr;
  logic                             ram_re;
  logic [DATA_SIZE-1:0]             ram_rdata;

  // Reader side: consumes requests and RAM data, produces pixels.
  modport slave (
    input  cache_rdy, decalage_w, decalage_h, cache_w, cache_h,
    input  req_valid, req_x, req_y, pix_ready, ram_rdata,
    output req_ready, pix_valid, pix_data, pix_hit, miss_cnt, ram_addr, ram_re
  );

  // Environment side: issues requests, owns the RAM, sinks pixels.
  modport master (
    output cache_rdy, decalage_w, decalage_h, cache_w, cache_h,
    output req_valid, req_x, req_y, pix_ready, ram_rdata,
    input  req_ready, pix_valid, pix_data, pix_hit, miss_cnt, ram_addr, ram_re
  );

endinterface

// File: rtl/cache_reader_pix_fifo.sv
// 3-entry synchronous FIFO holding {hit, pixel} results.
// Push visible at the head on the next cycle; head is registered storage.
// Push when full is dropped unless a pop happens in the same cycle.
module pix_fifo
  import cache_pkg::*;
#(
  parameter int WIDTH = PIX_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic [1:0]       occ_o
);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [1:0]       wr_q, rd_q, occ_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (occ_q != 2'd0);
  assign do_push = push_i && ((occ_q != 2'd3) || do_pop);

  // Storage, pointers and occupancy; push+pop together leaves occupancy unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= 2'd0;
      rd_q  <= 2'd0;
      occ_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (do_pop) rd_q <= ptr_inc(rd_q);
      case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign valid_o = (occ_q != 2'd0);
  assign occ_o   = occ_q;

endmodule

// File: rtl/cache_reader.sv
// Window hit test, cache RAM read and byte extraction; border value on a miss.
// Accept -> RAM read -> FIFO push; pixel valid two cycles after accept when FIFO empty.
// req_ready depends only on state, cache_rdy and in-flight count, never on pix_ready.
module cache_reader
  import cache_pkg::*;
#(
  parameter int               DATA_SIZE    = 32,
  parameter int               ADDR_SIZE_W  = 5,
  parameter int               ADDR_SIZE_H  = 5,
  parameter logic [PIX_W-1:0] BORDER_PIXEL = BORDER_PIXEL_DEF
) (
  input logic           p_clk,
  input logic           p_resetn,
  cache_reader_if.slave bus
);

  rd_state_t              state_q, state_d;
  logic                   latch_cfg;
  logic [9:0]             dw_q, dh_q, cw_q, ch_q;
  logic [15:0]            miss_cnt_q, miss_cnt_d;
  logic                   s1_valid_q, s1_hit_q;
  logic [1:0]             s1_sel_q;
  logic [1:0]             fifo_occ;
  logic [2:0]             inflight;
  logic                   req_ready, accept, hit;
  logic [10:0]            x_ext, y_ext;
  logic [ADDR_SIZE_W-1:0] rx;
  logic [ADDR_SIZE_H-1:0] ry;
  logic [PIX_W-1:0]       s1_pix;
  logic                   fifo_valid;
  logic [PIX_W:0]         fifo_dout;

  // Only registered terms plus cache_rdy gate acceptance; at most 3 results outstanding.
  assign inflight  = {1'b0, fifo_occ} + {2'b00, s1_valid_q};
  assign req_ready = (state_q == SERVE) && bus.cache_rdy && (inflight < 3'd3);
  assign accept    = bus.req_valid && req_ready;

  // Range test at 11 bits so dw+cw cannot wrap.
  assign x_ext = {{(11-ADDR_SIZE_W){1'b0}}, bus.req_x};
  assign y_ext = {{(11-ADDR_SIZE_H){1'b0}}, bus.req_y};
  assign hit   = (x_ext >= {1'b0, dw_q}) && (x_ext < ({1'b0, dw_q} + {1'b0, cw_q})) &&
                 (y_ext >= {1'b0, dh_q}) && (y_ext < ({1'b0, dh_q} + {1'b0, ch_q}));

  assign rx = bus.req_x - dw_q[ADDR_SIZE_W-1:0];
  assign ry = bus.req_y - dh_q[ADDR_SIZE_H-1:0];

  assign bus.ram_re    = accept && hit;
  assign bus.ram_addr  = bus.ram_re ? {2'b00, ry, rx[ADDR_SIZE_W-1:2]} : '0;
  assign bus.req_ready = req_ready;
  assign bus.miss_cnt  = miss_cnt_q;

  // Next state: window is latched and miss count cleared on IDLE->SERVE.
  always_comb begin
    state_d   = state_q;
    latch_cfg = 1'b0;
    case (state_q)
      IDLE: if (bus.cache_rdy) begin
        state_d   = SERVE;
        latch_cfg = 1'b1;
      end
      SERVE: if (!bus.cache_rdy) state_d = DRAIN;
      DRAIN: if (!s1_valid_q && (fifo_occ == 2'd0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Saturating count of accepted misses.
  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (latch_cfg)
      miss_cnt_d = '0;
    else if (accept && !hit && (miss_cnt_q != 16'hFFFF))
      miss_cnt_d = miss_cnt_q + 16'd1;
  end

  // State, latched window and miss counter.
  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      state_q    <= IDLE;
      miss_cnt_q <= '0;
      dw_q       <= '0;
      dh_q       <= '0;
      cw_q       <= '0;
      ch_q       <= '0;
    end else begin
      state_q    <= state_d;
      miss_cnt_q <= miss_cnt_d;
      if (latch_cfg) begin
        dw_q <= bus.decalage_w;
        dh_q <= bus.decalage_h;
        cw_q <= bus.cache_w;
        ch_q <= bus.cache_h;
      end
    end
  end

  // Stage 1 waits for RAM data alongside the hit flag and byte lane.
  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      s1_valid_q <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_sel_q   <= 2'd0;
    end else begin
      s1_valid_q <= accept;
      s1_hit_q   <= accept && hit;
      s1_sel_q   <= rx[1:0];
    end
  end

  // Byte 0 of the RAM word is bits 7:0.
  always_comb begin
    s1_pix = BORDER_PIXEL;
    if (s1_hit_q) s1_pix = bus.ram_rdata[PIX_W*s1_sel_q +: PIX_W];
  end

  pix_fifo #(.WIDTH(PIX_W + 1)) u_fifo (
    .clk_i   (p_clk),
    .rst_ni  (p_resetn),
    .push_i  (s1_valid_q),
    .din_i   ({s1_hit_q, s1_pix}),
    .pop_i   (bus.pix_ready),
    .dout_o  (fifo_dout),
    .valid_o (fifo_valid),
    .occ_o   (fifo_occ)
  );

  assign bus.pix_valid = fifo_valid;
  assign bus.pix_data  = fifo_dout[PIX_W-1:0];
  assign bus.pix_hit   = fifo_dout[PIX_W];

endmodule

// File: tb/tb_cache_reader.sv
// Scoreboard bench for cache_reader with a 1-cycle-latency RAM model.
// Inputs change on the falling edge; handshakes are evaluated 1 time unit later.
// Exercises hit/miss, streaming, backpressure, drain and mid-stream reset.
module tb_cache_reader;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_reader_if #(.DATA_SIZE(32), .ADDR_SIZE_W(5), .ADDR_SIZE_H(5)) bus ();

  cache_reader #(
    .DATA_SIZE(32), .ADDR_SIZE_W(5), .ADDR_SIZE_H(5), .BORDER_PIXEL(8'h00)
  ) dut (
    .p_clk   (clk),
    .p_resetn(rst_n),
    .bus     (bus)
  );

  logic [31:0] ram [0:1023];
  always @(posedge clk) if (bus.ram_re) bus.ram_rdata <= ram[bus.ram_addr];

  int        n_chk = 0, n_fail = 0;
  logic [8:0] sb[$];
  int        cdw, cdh, ccw, cch;
  int        acc_cnt = 0, pop_cnt = 0, win = 0, last_pop_win = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (window %0d)", tag, act, exp, win);
    end
  endtask

  // Evaluate both handshakes on settled values of the current window.
  task automatic mon();
    int x, y, rx, ry, addr;
    bit h;
    logic [31:0] w;
    logic [8:0] e;
    if (rst_n) begin
      if (bus.req_valid && bus.req_ready) begin
        x = int'(bus.req_x);
        y = int'(bus.req_y);
        h = (x >= cdw) && (x < cdw + ccw) && (y >= cdh) && (y < cdh + cch);
        if (h) begin
          rx   = x - cdw;
          ry   = y - cdh;
          addr = (ry << 3) | (rx >> 2);
          w    = ram[addr];
          e    = {1'b1, w[8*(rx%4) +: 8]};
          chk("ram_re", {31'd0, bus.ram_re}, 1);
          chk("ram_addr", {22'd0, bus.ram_addr}, addr);
        end else begin
          e = {1'b0, 8'h00};
          chk("ram_re_miss", {31'd0, bus.ram_re}, 0);
          chk("ram_addr_miss", {22'd0, bus.ram_addr}, 0);
        end
        sb.push_back(e);
        acc_cnt++;
      end
      if (bus.pix_valid && bus.pix_ready) begin
        chk("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("pix_data", {24'd0, bus.pix_data}, {24'd0, e[7:0]});
          chk("pix_hit", {31'd0, bus.pix_hit}, {31'd0, e[8]});
        end
        pop_cnt++;
        last_pop_win = win;
      end
    end
  endtask

  task automatic cyc();
    #1;
    mon();
    win++;
    @(negedge clk);
  endtask

  task automatic send(input int x, input int y);
    int n;
    n = acc_cnt;
    bus.req_valid = 1'b1;
    bus.req_x = 5'(x);
    bus.req_y = 5'(y);
    for (int i = 0; i < 50 && acc_cnt == n; i++) cyc();
    chk("send_accept", acc_cnt - n, 1);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    bus.pix_ready = 1'b1;
    for (int i = 0; i < 60 && sb.size() != 0; i++) cyc();
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic reconfig(input int dw, input int dh, input int cw, input int ch);
    bus.cache_rdy = 1'b0;
    drain();
    cyc();
    cyc();
    cdw = dw; cdh = dh; ccw = cw; cch = ch;
    bus.decalage_w = 10'(dw);
    bus.decalage_h = 10'(dh);
    bus.cache_w    = 10'(cw);
    bus.cache_h    = 10'(ch);
    bus.cache_rdy  = 1'b1;
    cyc();
    chk("cfg_req_ready", {31'd0, bus.req_ready}, 1);
    chk("cfg_miss_clr", {16'd0, bus.miss_cnt}, 0);
  endtask

  initial begin
    int s, n;
    logic [7:0] d0;
    for (int i = 0; i < 1024; i++) ram[i] = $urandom;
    ram[5] = 32'hDDCCBBAA;
    rst_n = 1'b0;
    bus.cache_rdy = 1'b0; bus.req_valid = 1'b0; bus.req_x = '0; bus.req_y = '0;
    bus.pix_ready = 1'b1; bus.ram_rdata = '0;
    bus.decalage_w = '0; bus.decalage_h = '0; bus.cache_w = '0; bus.cache_h = '0;
    @(negedge clk);
    chk("rst_pix_valid", {31'd0, bus.pix_valid}, 0);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 0);
    chk("rst_ram_re", {31'd0, bus.ram_re}, 0);
    chk("rst_miss_cnt", {16'd0, bus.miss_cnt}, 0);
    chk("rst_pix_data", {24'd0, bus.pix_data}, 0);
    chk("rst_state", dut.state_q, IDLE);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Single hit: word 5 byte 2, two-cycle latency.
    reconfig(0, 0, 32, 32);
    send(22, 0);
    chk("t1_lat1", {31'd0, bus.pix_valid}, 0);
    cyc();
    chk("t1_lat2", {31'd0, bus.pix_valid}, 1);
    chk("t1_data", {24'd0, bus.pix_data}, 32'hCC);
    cyc();
    drain();

    // Offset window: x=3,4,13,14 -> miss, hit, hit, miss.
    reconfig(4, 0, 10, 32);
    send(3, 0); send(4, 0); send(13, 0); send(14, 0);
    drain();
    chk("t2_miss_cnt", {16'd0, bus.miss_cnt}, 2);

    // cache_rdy drop with 2 pixels queued.
    bus.pix_ready = 1'b0;
    send(2, 0); send(5, 0);
    cyc(); cyc();
    chk("t5_queued", {31'd0, bus.pix_valid}, 1);
    chk("t5_miss_cnt", {16'd0, bus.miss_cnt}, 3);
    bus.cache_rdy = 1'b0; bus.req_valid = 1'b1; bus.req_x = 5'd6;
    n = acc_cnt;
    cyc();
    chk("t5_drain_state", dut.state_q, DRAIN);
    chk("t5_req_ready", {31'd0, bus.req_ready}, 0);
    cyc();
    chk("t5_no_accept", acc_cnt - n, 0);
    bus.req_valid = 1'b0;
    drain();
    cyc();
    chk("t5_idle", dut.state_q, IDLE);
    bus.cache_rdy = 1'b1;
    cyc();
    chk("t5_serve", dut.state_q, SERVE);
    chk("t5_miss_clr", {16'd0, bus.miss_cnt}, 0);

    // 64 back-to-back hits at full rate.
    reconfig(0, 0, 32, 32);
    s = win;
    n = pop_cnt;
    for (int i = 0; i < 64; i++) send($urandom_range(0, 31), $urandom_range(0, 31));
    chk("t3_no_stall", win - s, 64);
    drain();
    chk("t3_count", pop_cnt - n, 64);
    chk("t3_last_pix", last_pop_win - s, 65);

    // Backpressure: at most 3 accepts, held head stays stable.
    bus.pix_ready = 1'b0;
    n = acc_cnt;
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = 1'b1;
      bus.req_x = 5'($urandom_range(0, 31));
      bus.req_y = 5'($urandom_range(0, 31));
      cyc();
    end
    chk("t4_accepts", acc_cnt - n, 3);
    chk("t4_req_ready", {31'd0, bus.req_ready}, 0);
    d0 = bus.pix_data;
    cyc();
    chk("t4_stable", {24'd0, bus.pix_data}, {24'd0, d0});
    bus.req_valid = 1'b0;
    drain();

    // Reset in the middle of a stream.
    bus.pix_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1;
      bus.req_x = 5'($urandom_range(0, 31));
      cyc();
    end
    rst_n = 1'b0;
    #1;
    chk("t6_pix_valid", {31'd0, bus.pix_valid}, 0);
    chk("t6_req_ready", {31'd0, bus.req_ready}, 0);
    chk("t6_ram_re", {31'd0, bus.ram_re}, 0);
    chk("t6_state", dut.state_q, IDLE);
    sb.delete();
    cyc();
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    cyc(); cyc();
    bus.pix_ready = 1'b1;
    send(22, 0);
    drain();
    chk("t6_miss_cnt", {16'd0, bus.miss_cnt}, 0);

    chk("final_sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
